// File: rtl/icache_boot_pkg.sv
// ============================================================================
// Module : icache_boot_pkg
// Brief  : Shared types and constants for the icache boot controller slice.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package icache_boot_pkg;

    localparam int DEF_ADDR_W = 8;
    localparam int DEF_DATA_W = 32;
    localparam int DEF_DEPTH  = 256;

    // Active-low SRAM write strobe
    localparam logic SRAM_WR = 1'b0;
    localparam logic SRAM_RD = 1'b1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        DRAIN = 3'd2,
        RUN   = 3'd3,
        ERR   = 3'd4
    } boot_state_e;

endpackage

`default_nettype wire

// File: rtl/icache_boot_ctrl_if.sv
// ============================================================================
// Module : icache_boot_ctrl_if
// Brief  : Boot stream, fetch and SRAM-port signals of the icache boot controller.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface icache_boot_ctrl_if
    import icache_boot_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) ();
    logic              boot_start;
    logic [ADDR_W:0]   boot_len;
    logic              s_valid;
    logic [DATA_W-1:0] s_data;
    logic              s_ready;
    logic [ADDR_W-1:0] fetch_addr;
    logic              icache_en_wr;
    logic [ADDR_W-1:0] icache_addr;
    logic [DATA_W-1:0] icache_din;
    logic              pc_run;
    logic              busy;
    logic              done;
    logic              boot_err;

    modport master (
        output boot_start, boot_len, s_valid, s_data, fetch_addr,
        input  s_ready, icache_en_wr, icache_addr, icache_din,
               pc_run, busy, done, boot_err
    );

    modport slave (
        input  boot_start, boot_len, s_valid, s_data, fetch_addr,
        output s_ready, icache_en_wr, icache_addr, icache_din,
               pc_run, busy, done, boot_err
    );
endinterface

`default_nettype wire

// File: rtl/icache_port_mux.sv
// ============================================================================
// Module : icache_port_mux
// Brief  : Selects the registered loader port or the core fetch address.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module icache_port_mux
    import icache_boot_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              i_sel_fetch,
    input  logic              i_ld_en_wr,
    input  logic [ADDR_W-1:0] i_ld_addr,
    input  logic [DATA_W-1:0] i_ld_din,
    input  logic [ADDR_W-1:0] i_fetch_addr,
    output logic              o_en_wr,
    output logic [ADDR_W-1:0] o_addr,
    output logic [DATA_W-1:0] o_din
);
    always_comb begin
        if (i_sel_fetch) begin
            o_en_wr = SRAM_RD;
            o_addr  = i_fetch_addr;
            o_din   = '0;
        end else begin
            o_en_wr = i_ld_en_wr;
            o_addr  = i_ld_addr;
            o_din   = i_ld_din;
        end
    end
endmodule

`default_nettype wire

// File: rtl/icache_boot_ctrl.sv
// ============================================================================
// Module : icache_boot_ctrl
// Brief  : Boot loader owning the icache SRAM port; hands it to fetch on RUN.
//          Optional trailing checksum word: define ICACHE_BOOT_CKSUM_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module icache_boot_ctrl
    import icache_boot_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic clk,
    input  logic rst,
    icache_boot_ctrl_if.slave bus
);
    localparam logic [ADDR_W:0] c_DEPTH = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] c_ONE   = (ADDR_W+1)'(1);

    boot_state_e       r_state;
    boot_state_e       w_state_next;
    boot_state_e       w_start_target;
    logic [ADDR_W:0]   r_count;
    logic [ADDR_W:0]   r_len;
    logic [ADDR_W:0]   w_len_clip;
    logic              r_ld_en_wr;
    logic [ADDR_W-1:0] r_ld_addr;
    logic [DATA_W-1:0] r_ld_din;
    logic              r_done;
    logic              w_start;
    logic              w_hs;
    logic              w_wr;
    logic              w_s_ready;
    logic              w_pc_run;
    logic              w_busy;
    logic              w_boot_err;

    assign w_len_clip = (bus.boot_len > c_DEPTH) ? c_DEPTH : bus.boot_len;
    assign w_start    = bus.boot_start &&
                        ((r_state == IDLE) || (r_state == RUN) || (r_state == ERR));
    assign w_hs       = bus.s_valid && w_s_ready;

`ifdef ICACHE_BOOT_CKSUM_EN
    logic [DATA_W-1:0] r_sum;
    logic              w_is_data;
    // The word after len data words is the checksum and is never written.
    assign w_is_data      = (r_count != r_len);
    assign w_wr           = w_hs && w_is_data;
    assign w_start_target = LOAD;
`else
    assign w_wr           = w_hs;
    assign w_start_target = (w_len_clip == '0) ? RUN : LOAD;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:  if (w_start) w_state_next = w_start_target;
            LOAD: begin
`ifdef ICACHE_BOOT_CKSUM_EN
                if (w_hs && !w_is_data) begin
                    w_state_next = (bus.s_data == r_sum) ? DRAIN : ERR;
                end
`else
                if (w_hs && (r_count == r_len - c_ONE)) begin
                    w_state_next = DRAIN;
                end
`endif
            end
            DRAIN: w_state_next = RUN;
            RUN:   if (w_start) w_state_next = w_start_target;
            ERR:   if (w_start) w_state_next = w_start_target;
            default: w_state_next = IDLE;
        endcase
    end

    always_comb begin
        w_s_ready  = (r_state == LOAD);
        w_busy     = (r_state == LOAD) || (r_state == DRAIN);
        w_pc_run   = (r_state == RUN);
`ifdef ICACHE_BOOT_CKSUM_EN
        w_boot_err = (r_state == ERR);
`else
        w_boot_err = 1'b0;
`endif
    end

    // Loader datapath: each accepted word becomes a registered write one cycle later.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count    <= '0;
            r_len      <= '0;
            r_ld_en_wr <= SRAM_RD;
            r_ld_addr  <= '0;
            r_ld_din   <= '0;
            r_done     <= 1'b0;
`ifdef ICACHE_BOOT_CKSUM_EN
            r_sum      <= '0;
`endif
        end else begin
            r_done     <= (w_state_next == RUN) && ((r_state != RUN) || w_start);
            r_ld_en_wr <= SRAM_RD;
            if (w_start) begin
                r_len   <= w_len_clip;
                r_count <= '0;
`ifdef ICACHE_BOOT_CKSUM_EN
                r_sum   <= '0;
`endif
            end else if (w_wr) begin
                r_count    <= r_count + c_ONE;
                r_ld_en_wr <= SRAM_WR;
                r_ld_addr  <= r_count[ADDR_W-1:0];
                r_ld_din   <= bus.s_data;
`ifdef ICACHE_BOOT_CKSUM_EN
                r_sum      <= r_sum + bus.s_data;
`endif
            end
        end
    end

    icache_port_mux #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_port_mux (
        .i_sel_fetch  (w_pc_run),
        .i_ld_en_wr   (r_ld_en_wr),
        .i_ld_addr    (r_ld_addr),
        .i_ld_din     (r_ld_din),
        .i_fetch_addr (bus.fetch_addr),
        .o_en_wr      (bus.icache_en_wr),
        .o_addr       (bus.icache_addr),
        .o_din        (bus.icache_din)
    );

    assign bus.s_ready  = w_s_ready;
    assign bus.pc_run   = w_pc_run;
    assign bus.busy     = w_busy;
    assign bus.done     = r_done;
    assign bus.boot_err = w_boot_err;

endmodule

`default_nettype wire

// File: tb/tb_icache_boot_ctrl.sv
// ============================================================================
// Module : tb_icache_boot_ctrl
// Brief  : Scoreboard bench for icache_boot_ctrl with an SRAM model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_icache_boot_ctrl;
    localparam int ADDR_W = 8;
    localparam int DEPTH  = 256;
    localparam int DATA_W = 32;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_t;

    logic clk = 1'b0;
    logic rst;
    logic init_req;
    always #5 clk = ~clk;

    icache_boot_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    icache_boot_ctrl #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [DATA_W-1:0] sram    [DEPTH];
    logic [DATA_W-1:0] ref_mem [DEPTH];
    wr_t               exp_q[$];
    int                n_checks = 0;
    int                n_errors = 0;
    int                n_writes = 0;
    int                n_done   = 0;
    int                exp_done = 0;
    logic [ADDR_W-1:0] last_wr_addr = '0;
    int                m_len = 0;
    int                m_idx = 0;
    logic [DATA_W-1:0] m_sum = '0;

    // SRAM model: write commits at the end of a cycle with the strobe low.
    always @(posedge clk) begin
        if (init_req) begin
            for (int i = 0; i < DEPTH; i++) sram[i] <= 32'hDEAD0000 + i;
        end else if (bus.icache_en_wr == 1'b0) begin
            sram[bus.icache_addr] <= bus.icache_din;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (bus.icache_en_wr === 1'b0) begin
            n_writes++;
            last_wr_addr = bus.icache_addr;
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL spurious_write: got addr %0h data %0h expected no write",
                         bus.icache_addr, bus.icache_din);
            end else begin
                wr_t w;
                w = exp_q.pop_front();
                check("wr_addr", bus.icache_addr, w.addr);
                check("wr_data", bus.icache_din, w.data);
            end
        end
        if (bus.pc_run === 1'b1) begin
            check("run_addr", bus.icache_addr, bus.fetch_addr);
            check("run_en_wr", bus.icache_en_wr, 1);
        end
        if (bus.done === 1'b1) n_done++;
    end

    // Reference model: the k-th accepted word of a load lands at address k.
    function automatic void model_accept(input logic [DATA_W-1:0] d);
        wr_t w;
        if (m_idx < m_len) begin
            w.addr = ADDR_W'(m_idx);
            w.data = d;
            exp_q.push_back(w);
            ref_mem[m_idx] = d;
            m_idx++;
            m_sum += d;
        end
    endfunction

    task automatic start_load(input int len);
        bus.boot_start = 1'b1;
        bus.boot_len   = (ADDR_W+1)'(len);
        m_len = (len > DEPTH) ? DEPTH : len;
        m_idx = 0;
        m_sum = '0;
        @(posedge clk); #1;
        bus.boot_start = 1'b0;
    endtask

    task automatic send_word(input logic [DATA_W-1:0] d, input int gap, output bit ok);
        ok = 1'b0;
        bus.s_valid = 1'b0;
        repeat (gap) begin @(posedge clk); #1; end
        bus.s_valid = 1'b1;
        bus.s_data  = d;
        for (int t = 0; t < 64 && !ok; t++) begin
            if (bus.s_ready === 1'b1) begin
                @(posedge clk);
                model_accept(d);
                ok = 1'b1;
            end else begin
                @(posedge clk); #1;
            end
        end
        if (ok) #1;
        else begin
            n_checks++;
            n_errors++;
            $display("FAIL handshake_timeout: got s_ready=0 for 64 cycles expected 1");
        end
        bus.s_valid = 1'b0;
    endtask

    // mode: 0 random data, 1 0x1000+j, 2 j+1
    task automatic run_load(input int len, input int gap_lo, input int gap_hi,
                            input int mode, input bit bad_ck);
        bit                ok;
        int                total;
        logic [DATA_W-1:0] d;
        start_load(len);
`ifdef ICACHE_BOOT_CKSUM_EN
        total = m_len + 1;
`else
        total = m_len;
`endif
        check("start_pc_run", bus.pc_run, (total == 0));
        check("start_busy", bus.busy, (total != 0));
        check("start_boot_err", bus.boot_err, 0);
        if (total == 0) begin
            check("len0_done", bus.done, 1);
            exp_done++;
            return;
        end
        for (int j = 0; j < m_len; j++) begin
            d = (mode == 1) ? 32'h1000 + j : (mode == 2) ? 32'(j + 1) : $urandom;
            send_word(d, $urandom_range(gap_hi, gap_lo), ok);
            if (!ok) return;
        end
`ifdef ICACHE_BOOT_CKSUM_EN
        send_word(bad_ck ? m_sum + 1 : m_sum, 0, ok);
        if (!ok) return;
        if (bad_ck) begin
            check("err_boot_err", bus.boot_err, 1);
            check("err_pc_run", bus.pc_run, 0);
            check("err_s_ready", bus.s_ready, 0);
            return;
        end
`endif
        check("drain_pc_run", bus.pc_run, 0);
        check("drain_busy", bus.busy, 1);
        @(posedge clk); #1;
        check("run_pc_run", bus.pc_run, 1);
        check("run_done", bus.done, 1);
        exp_done++;
        @(posedge clk); #1;
        check("done_width", bus.done, 0);
    endtask

    task automatic mem_check(input string name);
        int bad;
        bad = 0;
        for (int i = 0; i < DEPTH; i++) if (sram[i] !== ref_mem[i]) bad++;
        check(name, bad, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish within 50000 cycles");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit ok;
        int w0;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = 32'hDEAD0000 + i;
        rst = 1'b1;
        init_req = 1'b1;
        bus.boot_start = 1'b0;
        bus.boot_len   = '0;
        bus.s_valid    = 1'b0;
        bus.s_data     = '0;
        bus.fetch_addr = '0;
        repeat (2) @(posedge clk);
        #1;
        bus.boot_start = 1'b1;
        bus.boot_len   = 9'd5;
        @(posedge clk); #1;
        bus.boot_start = 1'b0;
        check("rst_pc_run", bus.pc_run, 0);
        check("rst_s_ready", bus.s_ready, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_boot_err", bus.boot_err, 0);
        check("rst_en_wr", bus.icache_en_wr, 1);
        check("rst_addr", bus.icache_addr, 0);
        check("rst_din", bus.icache_din, 0);
        rst = 1'b0;
        init_req = 1'b0;
        @(posedge clk); #1;
        check("idle_after_rst_busy", bus.busy, 0);

        w0 = n_writes;
        run_load(45, 0, 0, 1, 1'b0);
        check("len45_writes", n_writes - w0, 45);
        mem_check("mem_len45");

        w0 = n_writes;
        run_load(4, 2, 2, 0, 1'b0);
        check("len4_writes", n_writes - w0, 4);

        bus.fetch_addr = 8'h07;
        #1;
        check("fetch_addr_07", bus.icache_addr, 8'h07);
        check("fetch_en_wr", bus.icache_en_wr, 1);
        bus.s_valid = 1'b1;
        bus.s_data  = 32'hBAD0BAD0;
        repeat (4) begin
            @(posedge clk); #1;
            check("run_s_ready", bus.s_ready, 0);
        end
        bus.s_valid = 1'b0;
        w0 = n_writes;
        run_load(2, 0, 1, 0, 1'b0);
        check("reload_writes", n_writes - w0, 2);
        mem_check("mem_reload");

        w0 = n_writes;
        start_load(45);
        for (int j = 0; j < 10; j++) send_word($urandom, 0, ok);
        rst = 1'b1;
        bus.s_valid = 1'b0;
        @(posedge clk); #1;
        check("midrst_pc_run", bus.pc_run, 0);
        check("midrst_s_ready", bus.s_ready, 0);
        check("midrst_en_wr", bus.icache_en_wr, 1);
        check("midrst_busy", bus.busy, 0);
        rst = 1'b0;
        m_len = 0;
        m_idx = 0;
        check("midrst_writes", n_writes - w0, 10);
        check("midrst_mem10", sram[10], ref_mem[10]);
        mem_check("mem_midrst");

        w0 = n_writes;
        run_load(0, 0, 0, 0, 1'b0);
        check("len0_writes", n_writes - w0, 0);

        w0 = n_writes;
        run_load(300, 0, 0, 0, 1'b0);
        check("len300_writes", n_writes - w0, 256);
        check("len300_last_addr", last_wr_addr, 8'hFF);
        mem_check("mem_len300");

`ifdef ICACHE_BOOT_CKSUM_EN
        run_load(3, 0, 0, 2, 1'b0);
        check("ck_good_err", bus.boot_err, 0);
        mem_check("mem_ck_good");
        run_load(3, 0, 0, 2, 1'b1);
        @(posedge clk); #1;
        check("ck_err_hold", bus.boot_err, 1);
        run_load(2, 0, 0, 0, 1'b0);
        check("ck_err_cleared", bus.boot_err, 0);
`endif

        for (int r = 0; r < 6; r++) begin
            run_load($urandom_range(40, 1), 0, 3, 0, 1'b0);
            repeat (3) begin
                bus.fetch_addr = ADDR_W'($urandom);
                @(posedge clk); #1;
            end
        end
        mem_check("mem_random");

        repeat (3) @(posedge clk);
        #1;
        check("queue_empty", exp_q.size(), 0);
        check("done_count", n_done, exp_done);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
